// File: rtl/sdfm_bus_master.sv
// Host-side initiator for the SDFM register bus: queued commands become
// setup/strobe/hold cycles with a 2-entry command FIFO and one response per command.
module sdfm_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        EXTCLK,
  input  logic        EXTRSTn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_we,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        WR,
  output logic        RD,
  output logic [15:0] ADDR,
  inout  wire  [31:0] DATA
);

  localparam logic [7:0] SETUP_N  = (SETUP_CYC  == 0) ? 8'd1 : 8'(SETUP_CYC);
  localparam logic [7:0] STROBE_N = (STROBE_CYC == 0) ? 8'd1 : 8'(STROBE_CYC);
  localparam logic [7:0] HOLD_N   = (HOLD_CYC   == 0) ? 8'd1 : 8'(HOLD_CYC);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  logic [1:0]        f_we;
  logic [1:0][15:0]  f_addr;
  logic [1:0][31:0]  f_wdata;
  logic              wptr, rptr;
  logic [1:0]        count;
  logic              push, pop;

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic              last;

  logic              cur_we;
  logic [15:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic              data_oe;
  logic              wr_n, rd_n, oe_n, we_src;
  logic [15:0]       addr_n;

  // ready ignores a same-cycle pop, so a full FIFO never takes a command
  assign cmd_ready = (count != 2'd2);
  assign push      = cmd_valid && cmd_ready;

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      count   <= 2'd0;
      f_we    <= '0;
      f_addr  <= '0;
      f_wdata <= '0;
    end else begin
      if (push) begin
        f_we[wptr]    <= cmd_we;
        f_addr[wptr]  <= cmd_addr;
        f_wdata[wptr] <= cmd_wdata;
        wptr          <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign last = (cnt == 8'd0);

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE:   if (count != 2'd0) begin pop = 1'b1; state_n = SETUP; end
      SETUP:  if (last) state_n = STROBE;
      STROBE: if (last) state_n = HOLD;
      HOLD:   if (last) state_n = RESP;
      RESP:   if (rsp_ready) begin
                if (count != 2'd0) begin pop = 1'b1; state_n = SETUP; end
                else state_n = IDLE;
              end
      default: state_n = IDLE;
    endcase
    cnt_n = last ? 8'd0 : cnt - 8'd1;
    if (state_n != state) begin
      case (state_n)
        SETUP:   cnt_n = SETUP_N - 8'd1;
        STROBE:  cnt_n = STROBE_N - 8'd1;
        HOLD:    cnt_n = HOLD_N - 8'd1;
        default: cnt_n = 8'd0;
      endcase
    end
  end

  // Bus pins are computed from the next state so they come straight off flops
  always_comb begin
    we_src = pop ? f_we[rptr] : cur_we;
    wr_n   = 1'b0;
    rd_n   = 1'b0;
    oe_n   = 1'b0;
    addr_n = 16'h0;
    case (state_n)
      SETUP, HOLD: begin
        addr_n = pop ? f_addr[rptr] : cur_addr;
        oe_n   = we_src;
      end
      STROBE: begin
        addr_n = cur_addr;
        oe_n   = we_src;
        wr_n   = we_src;
        rd_n   = !we_src;
      end
      default: ;
    endcase
  end

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      WR        <= 1'b0;
      RD        <= 1'b0;
      ADDR      <= 16'h0;
      data_oe   <= 1'b0;
      cur_we    <= 1'b0;
      cur_addr  <= 16'h0;
      cur_wdata <= 32'h0;
      rsp_rdata <= 32'h0;
    end else begin
      WR      <= wr_n;
      RD      <= rd_n;
      ADDR    <= addr_n;
      data_oe <= oe_n;
      if (pop) begin
        cur_we    <= f_we[rptr];
        cur_addr  <= f_addr[rptr];
        cur_wdata <= f_wdata[rptr];
        rsp_rdata <= 32'h0;
      end else if (state == STROBE && last && !cur_we) begin
        rsp_rdata <= DATA;
      end
    end
  end

  assign DATA      = data_oe ? cur_wdata : 32'hz;
  assign rsp_valid = (state == RESP);
  assign rsp_we    = cur_we;
  assign busy      = (state != IDLE) || (count != 2'd0);

endmodule

// File: tb/tb_sdfm_bus_master.sv
// Bench for sdfm_bus_master: vector table, directed multi-cycle corners and a
// randomized stream checked against a queue-based transaction model.
module tb_sdfm_bus_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] slave_fn(input logic [15:0] a);
    if (a == 16'h0724) return 32'hDEADBEEF;
    return {a ^ 16'hA5A5, a};
  endfunction

  // default-parameter instance
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        cmd_ready, rsp_valid, rsp_we, busy, WR, RD;
  logic [31:0] rsp_rdata;
  logic [15:0] ADDR;
  wire  [31:0] DATA;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_pat = 32'h0;

  assign DATA = RD ? slave_fn(ADDR) : (tb_drv ? tb_pat : 32'hz);

  sdfm_bus_master dut (
    .EXTCLK(clk), .EXTRSTn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .busy(busy), .WR(WR), .RD(RD), .ADDR(ADDR), .DATA(DATA)
  );

  // stretched-timing instance
  logic        c1_valid = 1'b0, c1_we = 1'b0, r1_ready = 1'b0;
  logic [15:0] c1_addr = 16'h0;
  logic [31:0] c1_wdata = 32'h0;
  logic        c1_ready, r1_valid, r1_we, busy1, WR1, RD1;
  logic [31:0] r1_rdata;
  logic [15:0] ADDR1;
  wire  [31:0] DATA1;

  assign DATA1 = RD1 ? slave_fn(ADDR1) : 32'hz;

  sdfm_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) dut1 (
    .EXTCLK(clk), .EXTRSTn(rst_n),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_we(c1_we),
    .cmd_addr(c1_addr), .cmd_wdata(c1_wdata),
    .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_we(r1_we), .rsp_rdata(r1_rdata),
    .busy(busy1), .WR(WR1), .RD(RD1), .ADDR(ADDR1), .DATA(DATA1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated transaction; bad counts cycles where the bus pins disagree with the command.
  task automatic run_one(input logic we, input logic [15:0] a, input logic [31:0] d,
                         output int lat, output int strb, output int bad,
                         output logic rwe, output logic [31:0] rd);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    tb_drv = !we; tb_pat = 32'h0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0; strb = 0; bad = 0;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (WR || RD) strb++;
      if (WR && RD) bad++;
      if (!rsp_valid) begin
        if (ADDR !== a) bad++;
        if (we && DATA !== d) bad++;
        if (!we && !RD && DATA !== 32'h0) bad++;
        if (we ? RD : WR) bad++;
      end
    end
    rwe = rsp_we; rd = rsp_rdata;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; tb_drv = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct { logic we; logic [31:0] rdata; } rsp_t;
  typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
  rsp_t exp_q[$];
  wr_t  wr_q[$];
  logic mon_on = 1'b0;
  logic wr_prev = 1'b0;

  // write-strobe monitor for the random phase: each WR burst must carry the next queued write
  always @(negedge clk) begin
    if (mon_on) begin
      if (WR && RD) chk("both strobes", {WR, RD}, 2'b00);
      if (WR && !wr_prev) begin
        if (wr_q.size() == 0) chk("unexpected write strobe", 1, 0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("rand bus write", {ADDR, DATA}, {w.a, w.d});
        end
      end
    end
    wr_prev <= WR;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int lat, strb, bad;
    logic rwe;
    logic [31:0] rd;
    logic [15:0] ta[3];
    logic [31:0] r0;
    int idx, cyc, stable_bad;
    int got, rcyc;
    localparam int N = 40;

    vt[0] = '{1'b1, 16'h0708, 32'h0000_0003, 32'h0};
    vt[1] = '{1'b0, 16'h0724, 32'hFFFF_FFFF, 32'hDEADBEEF};
    vt[2] = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 32'h0};
    vt[3] = '{1'b0, 16'h0000, 32'h1234_5678, 32'hA5A5_0000};
    vt[4] = '{1'b1, 16'h0000, 32'h0000_0000, 32'h0};
    vt[5] = '{1'b0, 16'hFF01, 32'h8000_0001, 32'h5AA4_FF01};

    // reset state
    #2;
    chk("rst WR", WR, 0);
    chk("rst RD", RD, 0);
    chk("rst ADDR", ADDR, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_we", rsp_we, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst busy", busy, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    #10 rst_n = 1'b1;

    foreach (vt[i]) begin
      run_one(vt[i].we, vt[i].addr, vt[i].wdata, lat, strb, bad, rwe, rd);
      chk($sformatf("vec%0d latency", i), lat, 5);
      chk($sformatf("vec%0d strobe cycles", i), strb, 2);
      chk($sformatf("vec%0d bus pins", i), bad, 0);
      chk($sformatf("vec%0d rsp_we", i), rwe, vt[i].we);
      chk($sformatf("vec%0d rsp_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("vec%0d idle after", i), {rsp_valid, busy}, 2'b00);
    end

    // three queued reads, first response held off for 10 cycles
    ta[0] = 16'h0100; ta[1] = 16'h0101; ta[2] = 16'h0724;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = ta[k]; cmd_wdata = $urandom;
      @(negedge clk);
      chk($sformatf("burst ready %0d", k), cmd_ready, 1);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("burst full", cmd_ready, 0);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("burst first rsp", rsp_valid, 1);
    r0 = rsp_rdata;
    stable_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== r0 || WR || RD) stable_bad++;
    end
    chk("backpressure stable", stable_bad, 0);
    rsp_ready = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 3 && cyc < 200) begin
      if (rsp_valid) begin
        chk($sformatf("burst rsp%0d", idx), {rsp_we, rsp_rdata}, {1'b0, slave_fn(ta[idx])});
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rsp_ready = 1'b0;
    chk("burst rsp count", idx, 3);

    // reset in the middle of a write strobe with a second write queued
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h1234; cmd_wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    cmd_addr = 16'h4321; cmd_wdata = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #2;
    chk("pre-reset WR", WR, 1);
    rst_n = 1'b0;
    #1;
    tb_drv = 1'b1; tb_pat = 32'hC0FF_EE00;
    #1;
    chk("reset WR", WR, 0);
    chk("reset ADDR", ADDR, 0);
    chk("reset DATA released", DATA, 32'hC0FF_EE00);
    chk("reset busy", busy, 0);
    chk("reset cmd_ready", cmd_ready, 1);
    tb_drv = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    stable_bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (rsp_valid || WR || RD || busy) stable_bad++;
    end
    chk("no rsp after reset", stable_bad, 0);

    // stretched timing read on the second instance
    @(posedge clk); #1;
    c1_valid = 1'b1; c1_we = 1'b0; c1_addr = 16'h0724; c1_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    c1_valid = 1'b0;
    lat = 0; strb = 0;
    while (!r1_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (RD1) strb++;
      if (WR1) strb += 100;
    end
    chk("long latency", lat, 10);
    chk("long RD cycles", strb, 4);
    chk("long rsp", {r1_we, r1_rdata}, {1'b0, 32'hDEADBEEF});
    r1_ready = 1'b1;
    @(posedge clk); #1;
    r1_ready = 1'b0;

    // randomized stream with random gaps and random rsp_ready
    mon_on = 1'b1;
    got = 0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          logic we, acc;
          logic [15:0] a;
          logic [31:0] d;
          int g;
          we = 1'($urandom_range(0, 1));
          a = 16'($urandom);
          d = $urandom;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
          g = 0;
          do begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1;
            g++;
          end while (!acc && g < 500);
          cmd_valid = 1'b0;
          if (!acc) chk("rand accept timeout", 0, 1);
          exp_q.push_back('{we, we ? 32'h0 : slave_fn(a)});
          if (we) wr_q.push_back('{a, d});
        end
      end
      begin
        rcyc = 0;
        while (got < N && rcyc < 5000) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("rand spurious rsp", 1, 0);
            else begin
              rsp_t e;
              e = exp_q.pop_front();
              chk($sformatf("rand rsp%0d", got), {rsp_we, rsp_rdata}, {e.we, e.rdata});
            end
            got++;
          end
          rcyc++;
        end
      end
    join
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    mon_on = 1'b0;
    chk("rand rsp count", got, N);
    chk("rand writes drained", wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
